// File: rtl/alu_mult_seq.sv
// Multi-cycle 32x32 -> 64-bit shift-add multiplier for MULT/MULTU.
// The shared ALU performs one add, sub or nor per cycle. The final
// product is held in the HI/LO registers.
module alu_mult_seq #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [3:0]  alu_ctl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI, S_FIX_INC, S_DONE
    } state_t;

    localparam logic [3:0] CTL_ADD = 4'd2;
    localparam logic [3:0] CTL_SUB = 4'd6;
    localparam logic [3:0] CTL_NOR = 4'd12;
    localparam logic [5:0] LAST_ITER = 6'(ITERS - 1);

    state_t      state, state_next;
    logic [31:0] mcand;
    logic [5:0]  count;
    logic        neg;      // product must be negated at the end
    logic        b_neg;    // op_b magnitude must be taken after op_a
    logic        lo_zero;  // negated low word was zero: carry into hi
    logic        carry;

    // The carry out of the 32-bit add is recovered from wrap-around.
    assign carry = (alu_out < hi);

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

    // State register and datapath registers for every state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that
        // all registers see the pre-edge values of each other.
        if (!rst_n) begin
            state   <= S_IDLE;
            hi      <= '0;
            lo      <= '0;
            mcand   <= '0;
            count   <= '0;
            neg     <= 1'b0;
            b_neg   <= 1'b0;
            lo_zero <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand <= op_a;
                        lo    <= op_b;
                        hi    <= '0;
                        count <= '0;
                        neg   <= is_signed & (op_a[31] ^ op_b[31]);
                        b_neg <= is_signed & op_b[31];
                    end
                end
                S_NEG_A: mcand <= alu_out;
                S_NEG_B: lo    <= alu_out;
                S_ITER: begin
                    // The 65-bit {carry, sum, lo} is shifted right by one.
                    hi    <= {carry, alu_out[31:1]};
                    lo    <= {alu_out[0], lo[31:1]};
                    count <= count + 6'd1;
                end
                S_FIX_LO: begin
                    lo      <= alu_out;
                    lo_zero <= alu_zero;
                end
                S_FIX_HI:  hi <= alu_out;
                S_FIX_INC: hi <= alu_out;
                default: ;
            endcase
        end
    end

    // Next-state and ALU port drive, decoded from state and registers.
    always_comb begin
        // NOTE: every output gets a default first, so no path through
        // the case statement can infer a latch.
        state_next = state;
        alu_ctl    = 4'd0;
        alu_a      = '0;
        alu_b      = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (is_signed && op_a[31])      state_next = S_NEG_A;
                    else if (is_signed && op_b[31]) state_next = S_NEG_B;
                    else                            state_next = S_ITER;
                end
            end
            S_NEG_A: begin
                alu_ctl    = CTL_SUB;
                alu_b      = mcand;
                state_next = b_neg ? S_NEG_B : S_ITER;
            end
            S_NEG_B: begin
                alu_ctl    = CTL_SUB;
                alu_b      = lo;
                state_next = S_ITER;
            end
            S_ITER: begin
                alu_ctl = CTL_ADD;
                alu_a   = hi;
                alu_b   = lo[0] ? mcand : 32'd0;
                if (count == LAST_ITER) state_next = neg ? S_FIX_LO : S_DONE;
            end
            S_FIX_LO: begin
                alu_ctl    = CTL_SUB;
                alu_b      = lo;
                state_next = S_FIX_HI;
            end
            S_FIX_HI: begin
                alu_ctl    = CTL_NOR;
                alu_a      = hi;
                alu_b      = hi;
                state_next = lo_zero ? S_FIX_INC : S_DONE;
            end
            S_FIX_INC: begin
                alu_ctl    = CTL_ADD;
                alu_a      = hi;
                alu_b      = 32'd1;
                state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq: a table of directed multiplies
// plus hand-written sequences for ignored starts and reset aborts.
module tb_alu_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a, op_b;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_zero;
    logic        busy, done;
    logic [31:0] hi, lo;

    int applied = 0;
    int miscompares = 0;

    alu_mult_seq #(.ITERS(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .alu_ctl(alu_ctl), .alu_a(alu_a),
        .alu_b(alu_b), .alu_out(alu_out), .alu_zero(alu_zero),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Behavioural model of the shared ALU.
    always_comb begin
        case (alu_ctl)
            4'd2:    alu_out = alu_a + alu_b;
            4'd6:    alu_out = alu_a - alu_b;
            4'd12:   alu_out = ~(alu_a | alu_b);
            default: alu_out = 32'd0;
        endcase
    end
    assign alu_zero = (alu_out == 32'd0);

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply and wait for done. Returns the cycle index of
    // done relative to the start edge, and counts busy and ALU-control
    // violations seen on the way.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_bad, output int ctl_bad);
        is_signed = sgn;
        op_a      = a;
        op_b      = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        op_a      = 32'hDEAD_BEEF;
        op_b      = 32'hDEAD_BEEF;
        lat       = 1;
        busy_bad  = 0;
        ctl_bad   = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_bad++;
            if (alu_ctl != 4'd2) ctl_bad++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, bb, cb, n_done;

        vecs[0] = '{1'b0, 32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F, 33};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[2] = '{1'b1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 36};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 35};
        vecs[4] = '{1'b1, 32'd0,         32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0000, 37};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 35};
        vecs[6] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 36};
        vecs[7] = '{1'b0, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000, 33};
        vecs[8] = '{1'b1, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 33};

        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
        tick(); tick();
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi/lo", {hi, lo}, 64'd0);
        check("reset alu port", {28'd0, alu_ctl, alu_a}, 64'd0);
        check("reset alu_b", 64'(alu_b), 64'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven multiplies.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, bb, cb);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            check($sformatf("vec%0d busy while running", i), 64'(bb), 64'd0);
            if (!vecs[i].sgn)
                check($sformatf("vec%0d alu_ctl add in ITER", i), 64'(cb), 64'd0);
            check($sformatf("vec%0d done idle ctl", i), {28'd0, alu_ctl, alu_a}, 64'd0);
            tick();
            check($sformatf("vec%0d done one cycle", i), {62'd0, done, busy}, 64'd0);
            check($sformatf("vec%0d hi/lo held", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
        end

        // Unsigned 7 x 9 with extra starts while busy and while in DONE.
        is_signed = 1'b0; op_a = 32'd7; op_b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1; n_done = 0;
        while (!done && lat < 100) begin
            if (lat == 4) begin
                start = 1'b1; op_a = 32'd100; op_b = 32'd100;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        check("ignored start latency", 64'(lat), 64'd33);
        // Start presented while in DONE must be ignored.
        op_a = 32'd5; op_b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("start in DONE ignored", {62'd0, busy, done}, 64'd0);
        check("7x9 product", {hi, lo}, 64'd63);
        // The cycle after DONE accepts a new start.
        op_a = 32'd4; op_b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        check("start after DONE accepted", 64'(busy), 64'd1);
        lat = 1;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        check("4x4 latency", 64'(lat), 64'd33);
        check("4x4 product", {hi, lo}, 64'd16);
        tick();

        // Reset in the middle of a multiply aborts it with no done.
        is_signed = 1'b0; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 9; c++) tick();
        check("busy before abort", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort busy", {62'd0, busy, done}, 64'd0);
        check("abort hi/lo", {hi, lo}, 64'd0);
        check("abort alu_ctl", 64'(alu_ctl), 64'd0);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) n_done++;
            tick();
        end
        check("no done after abort", 64'(n_done), 64'd0);

        // Reset wins over a start in the same cycle.
        op_a = 32'd3; op_b = 32'd3; start = 1'b1; rst_n = 1'b0;
        tick();
        start = 1'b0; rst_n = 1'b1;
        check("reset beats start", 64'(busy), 64'd0);

        run_op(1'b0, 32'd2, 32'd2, lat, bb, cb);
        check("2x2 after reset latency", 64'(lat), 64'd33);
        check("2x2 after reset", {hi, lo}, 64'd4);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
